// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end.
// Holds the NOP encoding, the fetch-queue entry layout and its default depth.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int          IFQ_DEPTH = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcplus4;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_mem.sv
// Storage array for the fetch/decode queue: DEPTH x 64 bits, no reset.
// Ports: clk, we/waddr/wdata (synchronous write), raddr/rdata (async read).
module ifq_mem
    import mips_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  ifq_entry_t    wdata,
    input  logic [AW-1:0] raddr,
    output ifq_entry_t    rdata
);

    ifq_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ifid_queue.sv
// Circular instruction queue between fetch and decode, flushed on PCSrc.
// Ports: clk, rst, instrF/pcplus4F/validF, StallF, PCSrc, StallD, instrD/pcplus4D/validD.
module ifid_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instrF,
    input  logic [31:0] pcplus4F,
    input  logic        validF,
    output logic        StallF,
    input  logic        PCSrc,
    input  logic        StallD,
    output logic [31:0] instrD,
    output logic [31:0] pcplus4D,
    output logic        validD
);

    localparam int           AW       = $clog2(DEPTH);
    localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    ifq_entry_t    wr_entry;
    ifq_entry_t    rd_entry;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // Flush kills both the incoming fetch and the outgoing decode slot.
    assign push = validF && !full && !PCSrc;
    assign pop  = !empty && !StallD && !PCSrc;

    assign wr_entry.instr   = instrF;
    assign wr_entry.pcplus4 = pcplus4F;

    ifq_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    always_ff @(posedge clk) begin
        if (rst || PCSrc) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign StallF   = full;
    assign validD   = !empty;
    assign instrD   = empty ? NOP_INSTR : rd_entry.instr;
    assign pcplus4D = empty ? 32'h0 : rd_entry.pcplus4;

endmodule

// File: tb/tb_ifid_queue.sv
// Self-checking bench for ifid_queue: directed phases plus random traffic.
// A queue-based model is compared against the DUT on every falling edge.
module tb_ifid_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instrF;
    logic [31:0] pcplus4F;
    logic        validF;
    logic        StallF;
    logic        PCSrc;
    logic        StallD;
    logic [31:0] instrD;
    logic [31:0] pcplus4D;
    logic        validD;

    int total = 0;
    int bad   = 0;
    bit live  = 0;
    logic [31:0] pc = 32'h0040_0004;

    logic [63:0] mq [$];

    always #5 clk = ~clk;

    ifid_queue dut (
        .clk      (clk),
        .rst      (rst),
        .instrF   (instrF),
        .pcplus4F (pcplus4F),
        .validF   (validF),
        .StallF   (StallF),
        .PCSrc    (PCSrc),
        .StallD   (StallD),
        .instrD   (instrD),
        .pcplus4D (pcplus4D),
        .validD   (validD)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a FIFO of at most 4 entries; flush and reset empty it.
    always @(posedge clk) begin
        bit was_full;
        bit do_pop;
        bit do_push;
        if (rst || PCSrc) begin
            mq.delete();
        end else begin
            was_full = (mq.size() == 4);
            do_pop   = (mq.size() > 0) && !StallD;
            do_push  = validF && !was_full;
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back({instrF, pcplus4F});
        end
    end

    always @(negedge clk) begin
        logic [63:0] head;
        if (live) begin
            head = (mq.size() > 0) ? mq[0] : 64'h0;
            check("validD",   {31'h0, validD}, {31'h0, mq.size() > 0});
            check("instrD",   instrD,   head[63:32]);
            check("pcplus4D", pcplus4D, head[31:0]);
            check("StallF",   {31'h0, StallF}, {31'h0, mq.size() == 4});
        end
    end

    task automatic cyc(input logic v, input logic [31:0] ins,
                       input logic br, input logic sd, input logic r);
        rst      = r;
        validF   = v;
        instrF   = ins;
        pcplus4F = pc;
        PCSrc    = br;
        StallD   = sd;
        pc       = pc + 32'd4;
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] w [5];
        rst = 1'b1; validF = 1'b0; instrF = '0; pcplus4F = '0;
        PCSrc = 1'b0; StallD = 1'b0;

        // Reset then idle
        cyc(0, 32'h0, 0, 0, 1);
        live = 1;
        cyc(0, 32'h0, 0, 0, 1);
        check("rst_validD", {31'h0, validD}, 32'h0);
        check("rst_instrD", instrD, 32'h0);
        check("rst_StallF", {31'h0, StallF}, 32'h0);
        cyc(0, 32'h0, 0, 0, 0);
        cyc(0, 32'h0, 0, 0, 0);
        check("idle_validD", {31'h0, validD}, 32'h0);

        // Stream
        cyc(1, 32'h2008_0001, 0, 0, 0);
        check("stream0", instrD, 32'h2008_0001);
        cyc(1, 32'h2009_0002, 0, 0, 0);
        check("stream1", instrD, 32'h2009_0002);
        cyc(1, 32'h200A_0003, 0, 0, 0);
        check("stream2", instrD, 32'h200A_0003);
        check("stream_valid", {31'h0, validD}, 32'h1);
        cyc(0, 32'h0, 0, 0, 0);
        check("stream_empty", {31'h0, validD}, 32'h0);

        // Fill
        for (int i = 0; i < 5; i++) w[i] = 32'hA000_0000 + i;
        for (int i = 0; i < 5; i++) begin
            cyc(1, w[i], 0, 1, 0);
            if (i == 3) check("fill_stallF", {31'h0, StallF}, 32'h1);
        end
        check("fill_head", instrD, w[0]);
        cyc(0, 32'h0, 0, 0, 0);
        check("drain_stallF", {31'h0, StallF}, 32'h0);
        check("drain_head", instrD, w[1]);
        for (int i = 0; i < 4; i++) cyc(0, 32'h0, 0, 0, 0);

        // Flush
        for (int i = 0; i < 3; i++) cyc(1, 32'hB000_0000 + i, 0, 1, 0);
        cyc(1, 32'hDEAD_BEEF, 1, 1, 0);
        check("flush_validD", {31'h0, validD}, 32'h0);
        cyc(1, 32'h1111_1111, 0, 0, 0);
        check("flush_next", instrD, 32'h1111_1111);
        cyc(0, 32'h0, 0, 0, 0);

        // Wrap-around with StallD toggling
        for (int i = 0; i < 10; i++) cyc(1, 32'hC000_0000 + i, 0, i[0], 0);
        for (int i = 0; i < 12; i++) cyc(0, 32'h0, 0, i[0], 0);

        // Reset mid-operation
        for (int i = 0; i < 4; i++) cyc(1, 32'hD000_0000 + i, 0, 1, 0);
        check("pre_rst_full", {31'h0, StallF}, 32'h1);
        cyc(0, 32'h0, 0, 1, 1);
        check("mrst_validD", {31'h0, validD}, 32'h0);
        check("mrst_StallF", {31'h0, StallF}, 32'h0);
        for (int i = 0; i < 3; i++) cyc(0, 32'h0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom,
                $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 199) == 0);
        end

        live = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
